// File: rtl/ddr_pkg.sv
// Shared DDR4 scheduler types: command codes, FSM states, bank entry, DIMM request codes, timing defaults.
package ddr_pkg;

  localparam int DEF_T_RCD = 14;
  localparam int DEF_T_RP  = 14;
  localparam int DEF_T_RAS = 32;
  localparam int DEF_T_CL  = 14;
  localparam int DEF_T_CWL = 12;

  localparam int CNT_W = 6;
  localparam int ROW_W = 17;
  localparam int COL_W = 10;

  typedef enum logic [2:0] {
    CMD_NOP, CMD_ACT, CMD_PRE, CMD_RD, CMD_WR
  } cmd_code_t;

  typedef enum logic [3:0] {
    S_IDLE, S_HIT, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_CAS, S_DATA, S_WAIT_AP
  } sched_state_t;

  typedef enum logic [1:0] {
    IDLE_R = 2'd0, RD_R = 2'd1, WR_R = 2'd2
  } dimm_req_t;

  typedef struct packed {
    logic             open;
    logic [ROW_W-1:0] row;
    logic [CNT_W-1:0] tras_cnt;
  } bank_state_t;

  // {cs_n, act_n, RAS, CAS, WE}; ACT takes RAS/CAS/WE from the row, so only its act_n matters here
  function automatic logic [4:0] cmd_pins(input cmd_code_t c);
    case (c)
      CMD_ACT: cmd_pins = 5'b00000;
      CMD_PRE: cmd_pins = 5'b01010;
      CMD_RD:  cmd_pins = 5'b01101;
      CMD_WR:  cmd_pins = 5'b01100;
      default: cmd_pins = 5'b01111;
    endcase
  endfunction

endpackage

// File: rtl/ddr_bank_tracker.sv
// Open-row table with per-bank tRAS down-counters and a hit/miss lookup on the incoming request.
module ddr_bank_tracker
  import ddr_pkg::*;
#(
  parameter int NB    = 16,
  parameter int IW    = 4,
  parameter int T_RAS = DEF_T_RAS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IW-1:0]    lk_bank,
  input  logic [ROW_W-1:0] lk_row,
  output logic             lk_hit,
  output logic             lk_miss,
  input  logic [IW-1:0]    cmd_bank,
  input  logic [ROW_W-1:0] cmd_row,
  input  logic             act_set,
  input  logic             bank_close,
  output logic             tras_done
);

  bank_state_t bank [NB];

  // Lookup: hit = open with same row, miss = open with another row, otherwise closed
  always_comb begin
    lk_hit    = bank[lk_bank].open && (bank[lk_bank].row == lk_row);
    lk_miss   = bank[lk_bank].open && (bank[lk_bank].row != lk_row);
    tras_done = (bank[cmd_bank].tras_cnt == '0);
  end

  // Table update: ACT opens and loads tRAS (zero-based), PRE/auto-precharge closes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NB; i++) bank[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (bank[i].tras_cnt != '0) bank[i].tras_cnt <= bank[i].tras_cnt - 1'b1;
        if (act_set && (cmd_bank == IW'(i))) begin
          bank[i].open     <= 1'b1;
          bank[i].row      <= cmd_row;
          bank[i].tras_cnt <= CNT_W'(T_RAS - 1);
        end else if (bank_close && (cmd_bank == IW'(i))) begin
          bank[i].open <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/ddr_cmd_scheduler.sv
// DDR4 command scheduler: one host request at a time, open-page policy, registered command/address pins.
// Build option: AUTO_PRECHARGE_EN selects auto-precharge on every CAS (closed-page policy).
module ddr_cmd_scheduler
  import ddr_pkg::*;
#(
  parameter int NBG   = 4,
  parameter int NBA   = 4,
  parameter int T_RCD = DEF_T_RCD,
  parameter int T_RP  = DEF_T_RP,
  parameter int T_RAS = DEF_T_RAS,
  parameter int T_CL  = DEF_T_CL,
  parameter int T_CWL = DEF_T_CWL
) (
  input  logic        CK_t,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [1:0]  req_bg,
  input  logic [1:0]  req_ba,
  input  logic [16:0] req_row,
  input  logic [9:0]  req_col,
  input  logic [3:0]  req_bl,
  output logic        cs_n,
  output logic        act_n,
  output logic        RAS_n_A16,
  output logic        CAS_n_A15,
  output logic        WE_n_A14,
  output logic        A13,
  output logic        A12_BC_n,
  output logic        A11,
  output logic        A10_AP,
  output logic [9:0]  A9_A0,
  output logic [1:0]  bg_addr,
  output logic [1:0]  ba_addr,
  output logic [1:0]  dimm_req,
  output logic        no_act_rdy,
  output logic        busy
);

`ifdef AUTO_PRECHARGE_EN
  localparam logic AP_FLAG = 1'b1;
`else
  localparam logic AP_FLAG = 1'b0;
`endif

  localparam int NB = NBG * NBA;
  localparam int IW = $clog2(NB);

  sched_state_t     state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  cmd_code_t        cmd;
  dimm_req_t        dreq_c;
  logic             nar_c, act_set, bank_close, accept;
  logic             lk_hit, lk_miss, tras_done;
  logic [4:0]       code_c;
  logic [13:0]      addr_c;
  logic [1:0]       bg_c, ba_c;

  logic [IW-1:0]    bank_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic             rw_q, bl8_q;

  assign accept = req_valid && req_ready;
  assign busy   = (state != S_IDLE);

  ddr_bank_tracker #(.NB(NB), .IW(IW), .T_RAS(T_RAS)) u_tracker (
    .clk        (CK_t),
    .rst        (reset),
    .lk_bank    ({req_bg, req_ba}),
    .lk_row     (req_row),
    .lk_hit     (lk_hit),
    .lk_miss    (lk_miss),
    .cmd_bank   (bank_q),
    .cmd_row    (row_q),
    .act_set    (act_set),
    .bank_close (bank_close),
    .tras_done  (tras_done)
  );

  // Request capture on handshake; datapath only, no reset needed
  always_ff @(posedge CK_t) begin
    if (accept) begin
      bank_q <= {req_bg, req_ba};
      row_q  <= req_row;
      col_q  <= req_col;
      rw_q   <= req_rw;
      bl8_q  <= (req_bl != 4'd4);
    end
  end

  // State and wait-counter register
  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic; waits load N-2 so that N cycles separate consecutive commands
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    cmd        = CMD_NOP;
    dreq_c     = IDLE_R;
    nar_c      = 1'b0;
    act_set    = 1'b0;
    bank_close = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (lk_hit)       state_nx = S_HIT;
          else if (lk_miss) state_nx = S_PRE;
          else              state_nx = S_ACT;
        end
      end
      S_PRE: begin
        if (tras_done) begin
          cmd        = CMD_PRE;
          bank_close = 1'b1;
          cnt_nx     = CNT_W'(T_RP - 2);
          state_nx   = S_WAIT_RP;
        end
      end
      S_WAIT_RP: begin
        if (cnt == '0) state_nx = S_ACT;
        else           cnt_nx   = cnt - 1'b1;
      end
      S_ACT: begin
        cmd      = CMD_ACT;
        act_set  = 1'b1;
        cnt_nx   = CNT_W'(T_RCD - 2);
        state_nx = S_WAIT_RCD;
      end
      S_WAIT_RCD: begin
        if (cnt == '0) state_nx = S_CAS;
        else           cnt_nx   = cnt - 1'b1;
      end
      S_HIT: begin
        nar_c    = 1'b1;
        state_nx = S_CAS;
      end
      S_CAS: begin
        cmd      = rw_q ? CMD_RD : CMD_WR;
        cnt_nx   = CNT_W'((rw_q ? T_CL : T_CWL) + (bl8_q ? 4 : 2) - 1);
        state_nx = S_DATA;
`ifdef AUTO_PRECHARGE_EN
        bank_close = 1'b1;
`endif
      end
      S_DATA: begin
        dreq_c = rw_q ? RD_R : WR_R;
        if (cnt == '0) begin
`ifdef AUTO_PRECHARGE_EN
          cnt_nx   = CNT_W'(T_RP - 2);
          state_nx = S_WAIT_AP;
`else
          state_nx = S_IDLE;
`endif
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      S_WAIT_AP: begin
        if (cnt == '0) state_nx = S_IDLE;
        else           cnt_nx   = cnt - 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Pin encoding for the command chosen this cycle
  always_comb begin
    code_c = cmd_pins(cmd);
    addr_c = '0;
    bg_c   = '0;
    ba_c   = '0;
    case (cmd)
      CMD_ACT: begin
        code_c = {2'b00, row_q[16:14]};
        addr_c = row_q[13:0];
        bg_c   = bank_q[3:2];
        ba_c   = bank_q[1:0];
      end
      CMD_PRE: begin
        bg_c = bank_q[3:2];
        ba_c = bank_q[1:0];
      end
      CMD_RD, CMD_WR: begin
        addr_c[9:0] = col_q;
        addr_c[10]  = AP_FLAG;
        addr_c[12]  = bl8_q;
        bg_c        = bank_q[3:2];
        ba_c        = bank_q[1:0];
      end
      default: ;
    endcase
  end

  // Registered outputs; reset deselects the bus and drops all handshakes at once
  always_ff @(posedge CK_t or posedge reset) begin
    if (reset) begin
      {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14} <= 5'h1F;
      {A13, A12_BC_n, A11, A10_AP, A9_A0}           <= '0;
      bg_addr    <= '0;
      ba_addr    <= '0;
      dimm_req   <= IDLE_R;
      no_act_rdy <= 1'b0;
      req_ready  <= 1'b0;
    end else begin
      {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14} <= code_c;
      {A13, A12_BC_n, A11, A10_AP, A9_A0}           <= addr_c;
      bg_addr    <= bg_c;
      ba_addr    <= ba_c;
      dimm_req   <= dreq_c;
      no_act_rdy <= nar_c;
      req_ready  <= (state_nx == S_IDLE);
    end
  end

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Directed bench for ddr_cmd_scheduler: per-scenario tasks with hand-computed cycle timings.
module tb_ddr_cmd_scheduler;

  logic        CK_t, reset;
  logic        req_valid, req_ready, req_rw;
  logic [1:0]  req_bg, req_ba;
  logic [16:0] req_row;
  logic [9:0]  req_col;
  logic [3:0]  req_bl;
  logic        cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14;
  logic        A13, A12_BC_n, A11, A10_AP;
  logic [9:0]  A9_A0;
  logic [1:0]  bg_addr, ba_addr, dimm_req;
  logic        no_act_rdy, busy;

  ddr_cmd_scheduler dut (
    .CK_t(CK_t), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col), .req_bl(req_bl),
    .cs_n(cs_n), .act_n(act_n), .RAS_n_A16(RAS_n_A16), .CAS_n_A15(CAS_n_A15), .WE_n_A14(WE_n_A14),
    .A13(A13), .A12_BC_n(A12_BC_n), .A11(A11), .A10_AP(A10_AP), .A9_A0(A9_A0),
    .bg_addr(bg_addr), .ba_addr(ba_addr), .dimm_req(dimm_req), .no_act_rdy(no_act_rdy), .busy(busy)
  );

`ifdef AUTO_PRECHARGE_EN
  localparam logic EXP_AP = 1'b1;
  localparam int   EXTRA  = 13;
`else
  localparam logic EXP_AP = 1'b0;
  localparam int   EXTRA  = 0;
`endif

  int n_chk = 0, n_pass = 0;
  int cyc = 0;

  // Observed transaction record (absolute cycle numbers, -1 when not seen)
  int          t0, a_act, a_pre, a_cas, a_nar, a_rdy, n_dreq, n_bad;
  logic [16:0] act_row;
  logic [1:0]  act_bg, act_ba;
  logic [9:0]  cas_col;
  logic        cas_rd, cas_ap, cas_bc, tmo;

  initial begin
    CK_t = 1'b0;
    forever #5 CK_t = ~CK_t;
  end

  always @(posedge CK_t) cyc <= cyc + 1;

  // Issue one request and record what appears on the pins until req_ready returns
  task automatic run_txn(input logic rw, input logic [1:0] bg, input logic [1:0] ba,
                         input logic [16:0] row, input logic [9:0] col, input logic [3:0] bl);
    logic [1:0] exp_req;
    exp_req = rw ? 2'd1 : 2'd2;
    a_act = -1; a_pre = -1; a_cas = -1; a_nar = -1; a_rdy = -1; n_dreq = 0; n_bad = 0; tmo = 1'b1;
    for (int i = 0; i < 100 && req_ready !== 1'b1; i++) begin @(posedge CK_t); #1; end
    req_valid = 1'b1; req_rw = rw; req_bg = bg; req_ba = ba; req_row = row; req_col = col; req_bl = bl;
    t0 = cyc;
    @(posedge CK_t); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cs_n === 1'b0 && act_n === 1'b0) begin
        a_act   = cyc;
        act_row = {RAS_n_A16, CAS_n_A15, WE_n_A14, A13, A12_BC_n, A11, A10_AP, A9_A0};
        act_bg  = bg_addr; act_ba = ba_addr;
      end else if ({cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14} === 5'b01010) begin
        a_pre = cyc;
      end else if ({cs_n, act_n, RAS_n_A16, CAS_n_A15} === 4'b0110) begin
        a_cas = cyc; cas_rd = WE_n_A14; cas_col = A9_A0; cas_ap = A10_AP; cas_bc = A12_BC_n;
      end
      if (no_act_rdy === 1'b1) a_nar = cyc;
      if (dimm_req === exp_req) n_dreq++;
      else if (dimm_req !== 2'd0) n_bad++;
      if (req_ready === 1'b1) begin a_rdy = cyc; tmo = 1'b0; break; end
      @(posedge CK_t); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_bg = '0; req_ba = '0;
    req_row = '0; req_col = '0; req_bl = 4'd8;
    repeat (3) @(posedge CK_t);
    #1;
    n_chk++; if ({cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14} !== 5'h1F) $display("FAIL rst_cmd_pins got %b want 11111", {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14}); else n_pass++;
    n_chk++; if ({A13, A12_BC_n, A11, A10_AP, A9_A0} !== 14'h0) $display("FAIL rst_addr got %h want 0", {A13, A12_BC_n, A11, A10_AP, A9_A0}); else n_pass++;
    n_chk++; if (dimm_req !== 2'd0) $display("FAIL rst_dimm_req got %0d want 0", dimm_req); else n_pass++;
    n_chk++; if (req_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", req_ready); else n_pass++;
    n_chk++; if ({no_act_rdy, busy} !== 2'b00) $display("FAIL rst_nar_busy got %b want 00", {no_act_rdy, busy}); else n_pass++;
    reset = 1'b0;
    @(posedge CK_t); #1;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL post_rst_ready got %b want 1", req_ready); else n_pass++;
  endtask

  task automatic test_write_closed();
    run_txn(1'b0, 2'd1, 2'd2, 17'h1A5, 10'h040, 4'd8);
    n_chk++; if (tmo !== 1'b0) $display("FAIL wr_timeout got %b want 0", tmo); else n_pass++;
    n_chk++; if (a_act - t0 !== 2) $display("FAIL wr_act_time got %0d want 2", a_act - t0); else n_pass++;
    n_chk++; if (act_row !== 17'h1A5) $display("FAIL wr_act_row got %h want 1a5", act_row); else n_pass++;
    n_chk++; if ({act_bg, act_ba} !== 4'b0110) $display("FAIL wr_act_bank got %b want 0110", {act_bg, act_ba}); else n_pass++;
    n_chk++; if (a_cas - a_act !== 14) $display("FAIL wr_trcd got %0d want 14", a_cas - a_act); else n_pass++;
    n_chk++; if ({cas_rd, cas_bc, cas_ap} !== {1'b0, 1'b1, EXP_AP}) $display("FAIL wr_cas_bits got %b want %b", {cas_rd, cas_bc, cas_ap}, {1'b0, 1'b1, EXP_AP}); else n_pass++;
    n_chk++; if (cas_col !== 10'h040) $display("FAIL wr_cas_col got %h want 040", cas_col); else n_pass++;
    n_chk++; if (n_dreq !== 16 || n_bad !== 0) $display("FAIL wr_dimm_req got %0d/%0d want 16/0", n_dreq, n_bad); else n_pass++;
    n_chk++; if (a_rdy - a_cas !== 16 + EXTRA) $display("FAIL wr_ready_back got %0d want %0d", a_rdy - a_cas, 16 + EXTRA); else n_pass++;
    n_chk++; if (a_pre !== -1 || a_nar !== -1) $display("FAIL wr_no_pre_nar got %0d,%0d want -1,-1", a_pre, a_nar); else n_pass++;
  endtask

  task automatic test_page_hit();
    run_txn(1'b1, 2'd1, 2'd2, 17'h1A5, 10'h080, 4'd8);
    n_chk++; if (tmo !== 1'b0) $display("FAIL hit_timeout got %b want 0", tmo); else n_pass++;
`ifdef AUTO_PRECHARGE_EN
    n_chk++; if (a_act - t0 !== 2) $display("FAIL ap_reopen_act got %0d want 2", a_act - t0); else n_pass++;
    n_chk++; if (a_nar !== -1) $display("FAIL ap_nar got %0d want -1", a_nar); else n_pass++;
    n_chk++; if (cas_ap !== 1'b1) $display("FAIL ap_a10 got %b want 1", cas_ap); else n_pass++;
`else
    n_chk++; if (a_act !== -1) $display("FAIL hit_no_act got %0d want -1", a_act); else n_pass++;
    n_chk++; if (a_nar - t0 !== 2) $display("FAIL hit_nar_time got %0d want 2", a_nar - t0); else n_pass++;
    n_chk++; if (a_cas - a_nar !== 1) $display("FAIL hit_rd_after_nar got %0d want 1", a_cas - a_nar); else n_pass++;
`endif
    n_chk++; if ({cas_rd, cas_col} !== {1'b1, 10'h080}) $display("FAIL hit_cas got %b/%h want 1/080", cas_rd, cas_col); else n_pass++;
    n_chk++; if (n_dreq !== 18 || n_bad !== 0) $display("FAIL hit_dimm_req got %0d/%0d want 18/0", n_dreq, n_bad); else n_pass++;
  endtask

  task automatic test_row_miss();
    int act0;
    run_txn(1'b0, 2'd0, 2'd0, 17'h00010, 10'h001, 4'd4);
    act0 = a_act;
    n_chk++; if (n_dreq !== 14) $display("FAIL bl4_wr_dimm_req got %0d want 14", n_dreq); else n_pass++;
    n_chk++; if (cas_bc !== 1'b0) $display("FAIL bl4_bc got %b want 0", cas_bc); else n_pass++;
    run_txn(1'b1, 2'd0, 2'd0, 17'h00002, 10'h003, 4'd8);
    n_chk++; if (tmo !== 1'b0) $display("FAIL miss_timeout got %b want 0", tmo); else n_pass++;
`ifdef AUTO_PRECHARGE_EN
    n_chk++; if (a_pre !== -1) $display("FAIL ap_miss_pre got %0d want -1", a_pre); else n_pass++;
    n_chk++; if (a_act - t0 !== 2) $display("FAIL ap_miss_act got %0d want 2", a_act - t0); else n_pass++;
`else
    n_chk++; if (a_pre - act0 !== 32) $display("FAIL miss_tras got %0d want 32", a_pre - act0); else n_pass++;
    n_chk++; if (a_act - a_pre !== 14) $display("FAIL miss_trp got %0d want 14", a_act - a_pre); else n_pass++;
`endif
    n_chk++; if (act_row !== 17'h00002) $display("FAIL miss_act_row got %h want 00002", act_row); else n_pass++;
    n_chk++; if (a_cas - a_act !== 14) $display("FAIL miss_trcd got %0d want 14", a_cas - a_act); else n_pass++;
  endtask

  task automatic test_back_to_back();
    run_txn(1'b1, 2'd2, 2'd3, 17'h00055, 10'h010, 4'd5);
    n_chk++; if (a_act - t0 !== 2) $display("FAIL b2b_a_act got %0d want 2", a_act - t0); else n_pass++;
    n_chk++; if (cas_bc !== 1'b1 || n_dreq !== 18) $display("FAIL b2b_bl_odd got %b/%0d want 1/18", cas_bc, n_dreq); else n_pass++;
    run_txn(1'b0, 2'd3, 2'd1, 17'h00077, 10'h020, 4'd4);
    n_chk++; if (a_act - t0 !== 2) $display("FAIL b2b_b_act got %0d want 2", a_act - t0); else n_pass++;
    n_chk++; if ({act_bg, act_ba, act_row} !== {2'd3, 2'd1, 17'h00077}) $display("FAIL b2b_b_addr got %b/%b/%h want 11/01/00077", act_bg, act_ba, act_row); else n_pass++;
    run_txn(1'b1, 2'd2, 2'd3, 17'h00055, 10'h011, 4'd8);
`ifdef AUTO_PRECHARGE_EN
    n_chk++; if (a_act - t0 !== 2 || a_nar !== -1) $display("FAIL ap_revisit got act %0d nar %0d want 2,-1", a_act - t0, a_nar); else n_pass++;
`else
    n_chk++; if (a_act !== -1 || a_nar - t0 !== 2) $display("FAIL b2b_revisit_hit got act %0d nar %0d want -1,2", a_act, a_nar - t0); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 100 && req_ready !== 1'b1; i++) begin @(posedge CK_t); #1; end
    req_valid = 1'b1; req_rw = 1'b0; req_bg = 2'd1; req_ba = 2'd1; req_row = 17'h5; req_col = 10'h0; req_bl = 4'd8;
    @(posedge CK_t); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge CK_t);
    #1;
    n_chk++; if (busy !== 1'b1) $display("FAIL mid_busy_before got %b want 1", busy); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_chk++; if ({cs_n, busy, req_ready} !== 3'b100) $display("FAIL mid_reset_now got %b want 100", {cs_n, busy, req_ready}); else n_pass++;
    @(posedge CK_t); #1;
    reset = 1'b0;
    run_txn(1'b0, 2'd1, 2'd1, 17'h5, 10'h0, 4'd8);
    n_chk++; if (a_act - t0 !== 2 || a_nar !== -1) $display("FAIL mid_reopen got act %0d nar %0d want 2,-1", a_act - t0, a_nar); else n_pass++;
    run_txn(1'b1, 2'd1, 2'd2, 17'h1A5, 10'h040, 4'd8);
    n_chk++; if (a_act - t0 !== 2 || a_nar !== -1) $display("FAIL mid_table_cleared got act %0d nar %0d want 2,-1", a_act - t0, a_nar); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_closed();
    test_page_hit();
    test_row_miss();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
